// File: rtl/manual_subtractor10_if.sv
// Front-panel bundle for the manual subtractor: raw button and enable in,
// registered count, reload pulse and three active-low 7-segment digits out.
interface manual_subtractor10_if;
  logic       buttonM;
  logic       selec;
  logic [7:0] count;
  logic       count_reached;
  logic [6:0] seg_centenas;
  logic [6:0] seg_decenas;
  logic [6:0] seg_unidades;

  modport master (
    output buttonM, selec,
    input  count, count_reached, seg_centenas, seg_decenas, seg_unidades
  );

  modport slave (
    input  buttonM, selec,
    output count, count_reached, seg_centenas, seg_decenas, seg_unidades
  );
endinterface

// File: rtl/manual_subtractor10.sv
// Manual down-counter: debounced button presses subtract STEP from the count,
// reload to START_VALUE after zero, and drive three registered 7-segment digits.
module manual_subtractor10 #(
  parameter int START_VALUE     = 150,
  parameter int STEP            = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic            clk,
  input logic            reset,
  manual_subtractor10_if.slave bus
);

  localparam int         CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [7:0] START_V = 8'(START_VALUE);
  localparam logic [7:0] STEP_V  = 8'(STEP);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {HOLD, RUN} state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db_level;
  logic             r_db_level_q;
  logic [CNT_W-1:0] r_db_cnt;
  logic             w_press;

  state_t     r_state;
  logic [7:0] r_count;
  logic       r_count_reached;

  function automatic logic [6:0] f_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Two-flop synchronizer, then a level is accepted only after it has been
  // stable for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_db_level   <= 1'b0;
      r_db_level_q <= 1'b0;
      r_db_cnt     <= '0;
    end else begin
      r_sync1      <= bus.buttonM;
      r_sync2      <= r_sync1;
      r_db_level_q <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_press = r_db_level & ~r_db_level_q;

  // Deasserting selec overrides everything, including a coincident press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= HOLD;
      r_count         <= START_V;
      r_count_reached <= 1'b0;
    end else begin
      r_count_reached <= 1'b0;
      if (!bus.selec) begin
        r_state <= HOLD;
        r_count <= START_V;
      end else begin
        case (r_state)
          HOLD: begin
            r_state <= RUN;
            r_count <= START_V;
          end
          RUN: begin
            if (w_press) begin
              if (r_count == 8'd0) begin
                r_count         <= START_V;
                r_count_reached <= 1'b1;
              end else if (r_count < STEP_V) begin
                r_count <= 8'd0;
              end else begin
                r_count <= r_count - STEP_V;
              end
            end
          end
          default: r_state <= HOLD;
        endcase
      end
    end
  end

  assign bus.count         = r_count;
  assign bus.count_reached = r_count_reached;

  // Digit 0 = hundreds, 1 = tens, 2 = units; no leading-zero blanking.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      localparam int DIV = (gi == 0) ? 100 : ((gi == 1) ? 10 : 1);
      logic [3:0] w_digit;
      logic [6:0] r_seg;

      assign w_digit = 4'((32'(r_count) / DIV) % 10);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_seg <= f_seg(4'((START_VALUE / DIV) % 10));
        end else begin
          r_seg <= f_seg(w_digit);
        end
      end
    end
  endgenerate

  assign bus.seg_centenas = g_digit[0].r_seg;
  assign bus.seg_decenas  = g_digit[1].r_seg;
  assign bus.seg_unidades = g_digit[2].r_seg;

endmodule
